// File: rtl/sm_divider_seq.sv
// Sequential sign-magnitude divider: non-restoring magnitude division, one
// quotient bit per cycle, followed by a single remainder-correction/sign cycle.
module sm_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE);
  // done is a one-cycle pulse and results stay valid until the next accepted start.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      p_q, p_d;       // signed partial remainder
  logic [N-1:0]    a_q, a_d;       // dividend bits shifting out, quotient bits in
  logic [N-1:0]    y_q, y_d;
  logic            xs_q, xs_d, ys_q, ys_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic            dz_q, dz_d;

  logic [N:0] y_ext, p_sh, p_step, p_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      y_q     <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      a_q     <= a_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    a_d     = a_q;
    y_d     = y_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    // Add or subtract y depending on the sign left by the previous step;
    // wrap-around of the shifted value is harmless since the result fits N+1 bits.
    y_ext  = {1'b0, y_q};
    p_sh   = {p_q[N-1:0], a_q[N-1]};
    p_step = p_q[N] ? (p_sh + y_ext) : (p_sh - y_ext);
    p_fix  = p_q[N] ? (p_q + y_ext) : p_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor[N-1:0] == '0) begin
            dz_d    = 1'b1;
            quot_d  = {1'b0, {N{1'b1}}};
            rem_d   = {dividend[N] & (|dividend[N-1:0]), dividend[N-1:0]};
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            a_d     = dividend[N-1:0];
            y_d     = divisor[N-1:0];
            xs_d    = dividend[N];
            ys_d    = divisor[N];
            p_d     = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = p_step;
        a_d   = {a_q[N-2:0], ~p_step[N]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        p_d     = p_fix;
        quot_d  = {(xs_q ^ ys_q) & (|a_q), a_q};
        rem_d   = {xs_q & (|p_fix[N-1:0]), p_fix[N-1:0]};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sm_divider_seq.sv
// Randomised and directed bench for sm_divider_seq (WIDTH=8) with a queue-based
// scoreboard fed by the driver and drained by a done-triggered monitor.
module tb_sm_divider_seq;
  localparam int W = 8;
  localparam int N = W - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_zero;
  logic [1:0]   dbg_state;

  sm_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_exp;
  logic         prev_done;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on magnitudes, then sign rules.
  function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int xm, ym, qm, rm;
    logic qs, rs;
    xm = int'(x[N-1:0]);
    ym = int'(y[N-1:0]);
    if (ym == 0) begin
      rs = x[N] && (xm != 0);
      return {1'b1, 1'b0, 7'h7F, rs, 7'(xm)};
    end
    qm = xm / ym;
    rm = xm % ym;
    qs = (x[N] ^ y[N]) && (qm != 0);
    rs = x[N] && (rm != 0);
    return {1'b0, qs, 7'(qm), rs, 7'(rm)};
  endfunction

  // Monitor: pop on every done, check pulse width and post-done hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("hold", {15'd0, div_zero, quotient, remainder}, {15'd0, last_exp});
      if (done) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
        end else begin
          last_exp = exp_q.pop_front();
          check("result", {15'd0, div_zero, quotient, remainder}, {15'd0, last_exp});
        end
      end
      prev_done = done;
    end
  end

  // Driver: issue one division; poke_at re-pulses start mid-operation,
  // abort_at asserts rst at that cycle instead of waiting for done.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input int poke_at, input int abort_at);
    int  exp_lat, lat, busy_cnt;
    bit  got;
    @(negedge clk);
    dividend = x;
    divisor  = y;
    start    = 1'b1;
    if (abort_at == 0) exp_q.push_back(model(x, y));
    exp_lat  = (y[N-1:0] == '0) ? 1 : N + 2;
    lat      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      start    = (c == poke_at);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        lat = c;
      end
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check("reset_abort", {13'd0, quotient, remainder, busy, done, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done expected done within 40 cycles at %0t", $time);
    end else begin
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    prev_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {13'd0, quotient, remainder, busy, done, div_zero}, 32'd0);
    rst = 1'b0;

    issue(8'h0D, 8'h83, 0, 0);
    issue(8'h87, 8'h02, 0, 0);
    issue(8'h7F, 8'h01, 0, 0);
    issue(8'h82, 8'h05, 0, 0);
    issue(8'h80, 8'h03, 0, 0);
    issue(8'h05, 8'h80, 0, 0);
    issue(8'h06, 8'h02, 0, 0);
    issue(8'hFF, 8'h7F, 0, 0);
    issue(8'h00, 8'h00, 0, 0);
    issue(8'h85, 8'h80, 0, 0);
    issue(8'h0D, 8'h83, 3, 0);
    issue(8'h7F, 8'h03, 0, 3);
    issue(8'h0D, 8'h83, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      if ($urandom_range(0, 15) == 0) y = {1'($urandom_range(0, 1)), 7'd0};
      else                            y = W'($urandom);
      issue(x, y, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : 0, 0);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
